// File: rtl/cic_pkg.sv
// Shared constants and comb-FSM state encoding for the CIC decimator and
// the downstream ISOP compensator.
package cic_pkg;

  localparam int unsigned CIC_N_STAGES = 6;
  localparam int unsigned CIC_R        = 128;
  localparam int unsigned CIC_LOG2R    = 7;
  localparam int unsigned CIC_W_OUT    = 44;
  localparam int unsigned CIC_ST_W     = $clog2(CIC_N_STAGES + 2);

  // IDLE, one state per comb stage, then OUT; Ck encodes as k
  typedef enum logic [CIC_ST_W-1:0] {
    ST_IDLE,
    ST_C1,
    ST_C2,
    ST_C3,
    ST_C4,
    ST_C5,
    ST_C6,
    ST_OUT
  } cic_state_t;

endpackage

// File: rtl/cic_integ_chain.sv
// Cascade of N modulo-2^W integrators; every stage updates each clock and
// stage k accumulates the previous-cycle value of stage k-1.
module cic_integ_chain
  import cic_pkg::*;
#(
  parameter int unsigned N_STAGES = CIC_N_STAGES,
  parameter int unsigned W        = CIC_W_OUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  output logic [W-1:0] i_n
);

  logic [W-1:0] integ [N_STAGES];

  // wrap-around is intended; the comb section cancels it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N_STAGES); k++) integ[k] <= '0;
    end else begin
      integ[0] <= integ[0] + x;
      for (int k = 1; k < int'(N_STAGES); k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  assign i_n = integ[N_STAGES-1];

endmodule

// File: rtl/cic_decim.sv
// CIC decimator: 1-bit bitstream in, W_OUT-bit signed words at fs/R with a
// one-clock ND strobe. Combs run sequentially on one shared subtractor.
module cic_decim
  import cic_pkg::*;
#(
  parameter int unsigned N_STAGES = CIC_N_STAGES,
  parameter int unsigned R        = CIC_R,
  parameter int unsigned W_OUT    = CIC_W_OUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CicIn,
  output logic signed [W_OUT-1:0] CicOut,
  output logic                    ND
);

  localparam int unsigned LOG2R = $clog2(R);

  if (R < N_STAGES + 3) begin : g_err_r_small
    $error("cic_decim: R must be >= N_STAGES+3 so a comb pass ends before the next capture");
  end
  if ((32'd1 << LOG2R) != R) begin : g_err_r_pow2
    $error("cic_decim: R must be a power of two");
  end
  if (N_STAGES != CIC_N_STAGES) begin : g_err_n
    $error("cic_decim: state enum in cic_pkg is sized for CIC_N_STAGES");
  end

  logic [W_OUT-1:0]        x;
  logic [W_OUT-1:0]        i_n;
  logic [LOG2R-1:0]        cnt;
  logic                    cap;
  cic_state_t              state, state_nxt;
  logic [CIC_ST_W-1:0]     stage;
  logic signed [W_OUT-1:0] acc, acc_nxt;
  logic signed [W_OUT-1:0] dly [N_STAGES];
  logic signed [W_OUT-1:0] dly_nxt [N_STAGES];
  logic signed [W_OUT-1:0] dly_sel;
  logic signed [W_OUT-1:0] diff;
  logic signed [W_OUT-1:0] out_nxt;
  logic                    nd_nxt;

  assign x = CicIn ? W_OUT'(1) : {W_OUT{1'b1}};

  cic_integ_chain #(
    .N_STAGES(N_STAGES),
    .W       (W_OUT)
  ) u_integ (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .i_n(i_n)
  );

  assign cap   = (cnt == LOG2R'(R - 1));
  assign stage = CIC_ST_W'(state) - CIC_ST_W'(1);

  // delay register feeding the shared subtractor for the active comb stage
  always_comb begin
    dly_sel = '0;
    for (int k = 0; k < int'(N_STAGES); k++) begin
      if (stage == CIC_ST_W'(k)) dly_sel = dly[k];
    end
  end

  assign diff = acc - dly_sel;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    out_nxt   = CicOut;
    nd_nxt    = 1'b0;
    for (int k = 0; k < int'(N_STAGES); k++) dly_nxt[k] = dly[k];
    case (state)
      ST_IDLE: begin
        if (cap) begin
          acc_nxt   = i_n;
          state_nxt = ST_C1;
        end
      end
      ST_OUT: begin
        out_nxt   = acc;
        nd_nxt    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        acc_nxt = diff;
        for (int k = 0; k < int'(N_STAGES); k++) begin
          if (stage == CIC_ST_W'(k)) dly_nxt[k] = acc;
        end
        state_nxt = (stage == CIC_ST_W'(N_STAGES - 1)) ? ST_OUT
                  : cic_state_t'(CIC_ST_W'(state) + CIC_ST_W'(1));
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      state  <= ST_IDLE;
      acc    <= '0;
      CicOut <= '0;
      ND     <= 1'b0;
      for (int k = 0; k < int'(N_STAGES); k++) dly[k] <= '0;
    end else begin
      cnt    <= cnt + LOG2R'(1);
      state  <= state_nxt;
      acc    <= acc_nxt;
      CicOut <= out_nxt;
      ND     <= nd_nxt;
      for (int k = 0; k < int'(N_STAGES); k++) dly[k] <= dly_nxt[k];
    end
  end

endmodule

// File: tb/tb_cic_decim.sv
// Scoreboard bench for cic_decim: each decimated output is predicted by
// convolving the +/-1 input history with the sinc^N impulse response.
module tb_cic_decim;
  import cic_pkg::*;

  localparam int W  = CIC_W_OUT;
  localparam int R  = CIC_R;
  localparam int N  = CIC_N_STAGES;
  localparam int HL = N * (R - 1) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                CicIn = 1'b0;
  logic signed [W-1:0] CicOut;
  logic                ND;

  cic_decim dut (
    .clk   (clk),
    .rst   (rst),
    .CicIn (CicIn),
    .CicOut(CicOut),
    .ND    (ND)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  exp_t   sbq[$];
  int     xs[$];
  longint h[HL];
  int     ecount;
  int     checks;
  int     failures;
  bit     prev_nd;
  longint last_out;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // impulse response of N cascaded length-R moving sums
  function automatic void build_h();
    longint tmp[HL];
    longint s;
    for (int j = 0; j < HL; j++) h[j] = (j < R) ? 64'sd1 : 64'sd0;
    for (int st = 1; st < N; st++) begin
      for (int n = 0; n < HL; n++) begin
        s = 0;
        for (int k = 0; k < R; k++) if (n - k >= 0) s += h[n - k];
        tmp[n] = s;
      end
      h = tmp;
    end
  endfunction

  // output captured at edge e sees inputs up to e-N (integrator chain delay)
  function automatic longint expect_at(input int e);
    longint s = 0;
    int t;
    for (int j = 0; j < HL; j++) begin
      t = e - N - j;
      if (t >= 1) s += h[j] * longint'(xs[t-1]);
    end
    return s;
  endfunction

  function automatic bit pat(input int mode, input int t, input int imp);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (t % 2) == 1;
      3:       return ((t - 1) % 4) != 3;
      4:       return t == imp;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic run(input int mode, input int ncyc, input int imp);
    exp_t item;
    bit b;
    for (int c = 0; c < ncyc; c++) begin
      b = pat(mode, xs.size() + 1, imp);
      CicIn = b;
      xs.push_back(b ? 1 : -1);
      @(posedge clk);
      ecount++;
      if (ecount % R == 0) begin
        item.val = expect_at(ecount);
        item.due = ecount + N + 1;
        sbq.push_back(item);
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    sbq.delete();
    xs.delete();
    ecount = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // monitor: compares every ND word, its timing, width and hold behaviour
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_nd  = 1'b0;
      last_out = 0;
    end else begin
      if (ND) begin
        check("nd_single_clock", longint'(prev_nd), 0);
        check("nd_expected_pending", longint'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("nd_edge", ecount, e.due);
          check("cicout", CicOut, e.val);
        end
        last_out = CicOut;
      end else begin
        check("cicout_hold", CicOut, last_out);
        if (sbq.size() > 0 && ecount > sbq[0].due) begin
          check("nd_timeout", ecount, sbq[0].due);
          void'(sbq.pop_front());
        end
      end
      prev_nd = ND;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int imp;
    checks   = 0;
    failures = 0;
    ecount   = 0;
    build_h();
    rst   = 1'b1;
    CicIn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cicout", CicOut, 0);
    check("reset_nd", longint'(ND), 0);
    #1 rst = 1'b0;

    // constant, alternating, 3/4 duty, impulse and random streams
    for (int mode = 0; mode < 7; mode++) begin
      imp = int'($urandom_range(200, 900));
      run(mode, 10 * R + 12, imp);
      check("drained", sbq.size(), 0);
      do_reset();
    end

    // asynchronous reset while the comb pass sits in C3
    run(0, 3 * R + 2, 0);
    check("pre_abort_nonzero", longint'(CicOut != 0), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_cicout", CicOut, 0);
    check("abort_nd", longint'(ND), 0);
    do_reset();
    run(0, 2 * R + 12, 0);
    check("drained_final", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
